// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX/MEM store-data bypass selects, load-use and MDU
// scoreboard stall detection, and a saturating stall-cycle counter.
module hazard_fwd_unit #(
    parameter int REG_AW    = 5,
    parameter int MDU_LAT   = 4,
    parameter int LINK_EXCL = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_mdu_op,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic              idex_mdu_start,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] exmem_rt,
    input  logic              exmem_regwrite,
    input  logic              exmem_memwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    input  logic              perf_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_c,
    output logic              stall,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};
    localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);
    localparam logic [3:0]        MDU_LOAD = 4'(MDU_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // Register 0 is hardwired and the jal link register may be excluded.
    function automatic logic fwd_ok(input logic [REG_AW-1:0] r);
        logic ok;
        ok = (r != ZERO_REG);
        if (LINK_EXCL != 0) begin
            ok = ok && (r != LINK_REG);
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_we
    );
        logic [1:0] sel;
        if (mem_we && fwd_ok(mem_rd) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_we && fwd_ok(wb_rd) && (wb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [3:0]        mdu_cnt_q, mdu_cnt_d;
    logic [REG_AW-1:0] mdu_rd_q, mdu_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use_s;
    logic              mdu_pend_s;
    logic [REG_AW-1:0] mdu_reg_s;
    logic              mdu_hz_s;

    // Same-cycle forwarding selects and stall decision, forced low in reset.
    always_comb begin
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        fwd_c      = 1'b0;
        stall      = 1'b0;
        load_use_s = 1'b0;
        mdu_pend_s = 1'b0;
        mdu_reg_s  = ZERO_REG;
        mdu_hz_s   = 1'b0;
        if (rstn) begin
            fwd_a = fwd_sel(idex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
            fwd_b = fwd_sel(idex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
            fwd_c = exmem_memwrite && memwb_regwrite && fwd_ok(memwb_rd) && (memwb_rd == exmem_rt);
            load_use_s = idex_memread && idex_regwrite && (idex_rd != ZERO_REG) &&
                         ((id_uses_rs && (id_rs == idex_rd)) || (id_uses_rt && (id_rt == idex_rd)));
            // An MDU op entering EX this cycle is already a pending writer.
            mdu_pend_s = (mdu_cnt_q != 4'd0) || idex_mdu_start;
            mdu_reg_s  = idex_mdu_start ? idex_rd : mdu_rd_q;
            mdu_hz_s   = mdu_pend_s &&
                         ((id_uses_rs && (mdu_reg_s != ZERO_REG) && (id_rs == mdu_reg_s)) ||
                          (id_uses_rt && (mdu_reg_s != ZERO_REG) && (id_rt == mdu_reg_s)) ||
                          id_mdu_op);
            stall = load_use_s || mdu_hz_s;
        end else begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
            fwd_c = 1'b0;
            stall = 1'b0;
        end
    end

    // Next state for the MDU scoreboard and the saturating stall counter.
    always_comb begin
        mdu_cnt_d   = mdu_cnt_q;
        mdu_rd_d    = mdu_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (idex_mdu_start) begin
            mdu_cnt_d = MDU_LOAD;
            mdu_rd_d  = idex_rd;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end
        if (perf_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdu_cnt_q   <= 4'd0;
            mdu_rd_q    <= ZERO_REG;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            mdu_rd_q    <= mdu_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_busy  = (mdu_cnt_q != 4'd0);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two instances (link-excluded/LAT4/4-bit counter and
// link-forwarded/LAT1/16-bit counter) checked against a queue-based scoreboard.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_rd, exmem_rd, exmem_rt, memwb_rd;
    logic       id_uses_rs, id_uses_rt, id_mdu_op;
    logic       idex_regwrite, idex_memread, idex_mdu_start;
    logic       exmem_regwrite, exmem_memwrite, memwb_regwrite, perf_clr;

    logic [1:0]  fwd_a1, fwd_b1, fwd_a2, fwd_b2;
    logic        fwd_c1, stall1, busy1, fwd_c2, stall2, busy2;
    logic [3:0]  scnt1;
    logic [15:0] scnt2;

    int n_checks = 0;
    int n_errors = 0;
    int seen_stall = 0;
    int seen_busy = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    logic [3:0]  m1_cnt, m2_cnt;
    logic [4:0]  m1_rd, m2_rd;
    logic [3:0]  m1_sc;
    logic [15:0] m2_sc;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(5), .MDU_LAT(4), .LINK_EXCL(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_mdu_start(idex_mdu_start),
        .exmem_rd(exmem_rd), .exmem_rt(exmem_rt), .exmem_regwrite(exmem_regwrite),
        .exmem_memwrite(exmem_memwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .perf_clr(perf_clr), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .fwd_c(fwd_c1),
        .stall(stall1), .mdu_busy(busy1), .stall_cnt(scnt1)
    );

    hazard_fwd_unit #(.REG_AW(5), .MDU_LAT(1), .LINK_EXCL(0), .CNT_W(16)) u_dut2 (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_mdu_start(idex_mdu_start),
        .exmem_rd(exmem_rd), .exmem_rt(exmem_rt), .exmem_regwrite(exmem_regwrite),
        .exmem_memwrite(exmem_memwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .perf_clr(perf_clr), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .fwd_c(fwd_c2),
        .stall(stall2), .mdu_busy(busy2), .stall_cnt(scnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:  return {30'd0, fwd_a1};
            1:  return {30'd0, fwd_b1};
            2:  return {31'd0, fwd_c1};
            3:  return {31'd0, stall1};
            4:  return {31'd0, busy1};
            5:  return {28'd0, scnt1};
            6:  return {30'd0, fwd_a2};
            7:  return {30'd0, fwd_b2};
            8:  return {31'd0, fwd_c2};
            9:  return {31'd0, stall2};
            10: return {31'd0, busy2};
            11: return {16'd0, scnt2};
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic logic m_valid(input logic [4:0] r, input bit le);
        return (r != 5'd0) && !(le && (r == 5'd31));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input bit le);
        if (!rstn) return 2'b00;
        if (exmem_regwrite && m_valid(exmem_rd, le) && exmem_rd == src) return 2'b10;
        if (memwb_regwrite && m_valid(memwb_rd, le) && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_fwdc(input bit le);
        return rstn && exmem_memwrite && memwb_regwrite && m_valid(memwb_rd, le) && (memwb_rd == exmem_rt);
    endfunction

    function automatic logic m_stall(input logic [3:0] cnt, input logic [4:0] mrd);
        logic lu, pend, hz;
        logic [4:0] preg;
        lu = idex_memread && idex_regwrite && (idex_rd != 5'd0) &&
             ((id_uses_rs && id_rs == idex_rd) || (id_uses_rt && id_rt == idex_rd));
        pend = (cnt != 4'd0) || idex_mdu_start;
        preg = idex_mdu_start ? idex_rd : mrd;
        hz = pend && ((id_uses_rs && preg != 5'd0 && id_rs == preg) ||
                      (id_uses_rt && preg != 5'd0 && id_rt == preg) || id_mdu_op);
        return rstn && (lu || hz);
    endfunction

    // One cycle: push expectations, compare, then advance the model on the edge.
    task automatic step(input string tag);
        logic s1, s2;
        exp_t e;
        if (!rstn) begin
            m1_cnt = 4'd0; m1_rd = 5'd0; m1_sc = 4'd0;
            m2_cnt = 4'd0; m2_rd = 5'd0; m2_sc = 16'd0;
        end
        s1 = m_stall(m1_cnt, m1_rd);
        s2 = m_stall(m2_cnt, m2_rd);
        sb_q.push_back('{{tag, ".fa1"}, 0, {30'd0, m_fwd(idex_rs, 1'b1)}});
        sb_q.push_back('{{tag, ".fb1"}, 1, {30'd0, m_fwd(idex_rt, 1'b1)}});
        sb_q.push_back('{{tag, ".fc1"}, 2, {31'd0, m_fwdc(1'b1)}});
        sb_q.push_back('{{tag, ".st1"}, 3, {31'd0, s1}});
        sb_q.push_back('{{tag, ".bz1"}, 4, {31'd0, m1_cnt != 4'd0}});
        sb_q.push_back('{{tag, ".sc1"}, 5, {28'd0, m1_sc}});
        sb_q.push_back('{{tag, ".fa2"}, 6, {30'd0, m_fwd(idex_rs, 1'b0)}});
        sb_q.push_back('{{tag, ".fb2"}, 7, {30'd0, m_fwd(idex_rt, 1'b0)}});
        sb_q.push_back('{{tag, ".fc2"}, 8, {31'd0, m_fwdc(1'b0)}});
        sb_q.push_back('{{tag, ".st2"}, 9, {31'd0, s2}});
        sb_q.push_back('{{tag, ".bz2"}, 10, {31'd0, m2_cnt != 4'd0}});
        sb_q.push_back('{{tag, ".sc2"}, 11, {16'd0, m2_sc}});
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
        if (stall1) seen_stall++;
        if (busy1) seen_busy++;
        @(posedge clk);
        if (!rstn) begin
            m1_cnt = 4'd0; m1_rd = 5'd0; m1_sc = 4'd0;
            m2_cnt = 4'd0; m2_rd = 5'd0; m2_sc = 16'd0;
        end else begin
            if (idex_mdu_start) begin
                m1_cnt = 4'd4; m1_rd = idex_rd;
                m2_cnt = 4'd1; m2_rd = idex_rd;
            end else begin
                if (m1_cnt != 4'd0) m1_cnt = m1_cnt - 4'd1;
                if (m2_cnt != 4'd0) m2_cnt = m2_cnt - 4'd1;
            end
            if (perf_clr) m1_sc = 4'd0;
            else if (s1 && m1_sc != 4'hf) m1_sc = m1_sc + 4'd1;
            if (perf_clr) m2_sc = 16'd0;
            else if (s2 && m2_sc != 16'hffff) m2_sc = m2_sc + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_op = 1'b0;
        idex_rs = 5'd0; idex_rt = 5'd0; idex_rd = 5'd0;
        idex_regwrite = 1'b0; idex_memread = 1'b0; idex_mdu_start = 1'b0;
        exmem_rd = 5'd0; exmem_rt = 5'd0; exmem_regwrite = 1'b0; exmem_memwrite = 1'b0;
        memwb_rd = 5'd0; memwb_regwrite = 1'b0; perf_clr = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] pool [6];
        pool = '{5'd0, 5'd5, 5'd8, 5'd12, 5'd31, 5'd9};
        return pool[$urandom_range(0, 5)];
    endfunction

    initial begin
        rstn = 1'b0;
        idle_inputs();
        m1_cnt = 4'd0; m1_rd = 5'd0; m1_sc = 4'd0;
        m2_cnt = 4'd0; m2_rd = 5'd0; m2_sc = 16'd0;
        @(negedge clk);

        // Outputs held low during reset even with a forwarding match present.
        exmem_regwrite = 1'b1; exmem_rd = 5'd8; idex_rs = 5'd8;
        step("rst");
        check_val("rst_fwd_a", {30'd0, fwd_a1}, 32'd0);
        rstn = 1'b1;

        memwb_regwrite = 1'b1; memwb_rd = 5'd8;
        step("prio");
        check_val("prio_exmem", {30'd0, fwd_a1}, 32'd2);
        exmem_regwrite = 1'b0;
        step("prio_wb");
        check_val("prio_memwb", {30'd0, fwd_a1}, 32'd1);
        idex_rs = 5'd0;
        step("prio_r0");
        check_val("prio_r0", {30'd0, fwd_a1}, 32'd0);

        idle_inputs();
        exmem_regwrite = 1'b1; exmem_rd = 5'd31; idex_rt = 5'd31;
        step("link");
        check_val("link_excl", {30'd0, fwd_b1}, 32'd0);
        check_val("link_fwd", {30'd0, fwd_b2}, 32'd2);

        idle_inputs();
        exmem_memwrite = 1'b1; exmem_rt = 5'd9; memwb_rd = 5'd9; memwb_regwrite = 1'b1;
        step("store");
        check_val("store_fwd", {31'd0, fwd_c1}, 32'd1);
        memwb_rd = 5'd0;
        step("store_r0");
        check_val("store_r0", {31'd0, fwd_c1}, 32'd0);

        idle_inputs();
        perf_clr = 1'b1;
        step("clr0");
        perf_clr = 1'b0;
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        step("lu");
        check_val("lu_stall", {31'd0, stall1}, 32'd1);
        idex_memread = 1'b0;
        step("lu_bub");
        check_val("lu_cnt", {28'd0, scnt1}, 32'd1);
        idex_memread = 1'b1; id_uses_rt = 1'b0;
        step("lu_nouse");
        check_val("lu_nouse", {31'd0, stall1}, 32'd0);

        idle_inputs();
        perf_clr = 1'b1;
        step("clr1");
        perf_clr = 1'b0;
        seen_stall = 0; seen_busy = 0;
        id_rs = 5'd12; id_uses_rs = 1'b1;
        idex_mdu_start = 1'b1; idex_rd = 5'd12;
        step("mdu_go");
        idex_mdu_start = 1'b0; idex_rd = 5'd0;
        for (int i = 0; i < 7; i++) step("mdu");
        check_val("mdu_stall_cycles", seen_stall, 32'd5);
        check_val("mdu_busy_cycles", seen_busy, 32'd4);
        check_val("mdu_stall_cnt", {28'd0, scnt1}, 32'd5);

        for (int i = 0; i < 300; i++) begin
            id_rs = pick_reg(); id_rt = pick_reg();
            id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
            id_mdu_op = ($urandom_range(0, 9) == 0);
            idex_rs = pick_reg(); idex_rt = pick_reg(); idex_rd = pick_reg();
            idex_regwrite = 1'($urandom_range(0, 1)); idex_memread = 1'($urandom_range(0, 1));
            idex_mdu_start = ($urandom_range(0, 7) == 0);
            exmem_rd = pick_reg(); exmem_rt = pick_reg();
            exmem_regwrite = 1'($urandom_range(0, 1)); exmem_memwrite = 1'($urandom_range(0, 1));
            memwb_rd = pick_reg(); memwb_regwrite = 1'($urandom_range(0, 1));
            perf_clr = ($urandom_range(0, 31) == 0);
            step("rnd");
        end

        idle_inputs();
        for (int i = 0; i < 5; i++) step("drain");
        perf_clr = 1'b1;
        step("clr2");
        perf_clr = 1'b0;
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        for (int i = 0; i < 20; i++) step("sat");
        check_val("sat_hold", {28'd0, scnt1}, 32'd15);
        perf_clr = 1'b1;
        step("clr_vs_stall");
        check_val("clr_priority", {28'd0, scnt1}, 32'd0);

        idle_inputs();
        id_rs = 5'd12; id_uses_rs = 1'b1;
        idex_mdu_start = 1'b1; idex_rd = 5'd12;
        step("mdu2_go");
        idex_mdu_start = 1'b0; idex_rd = 5'd0;
        step("mdu2");
        check_val("mid_busy_pre", {31'd0, busy1}, 32'd1);
        rstn = 1'b0;
        step("rst_mid");
        check_val("rst_mid_busy", {31'd0, busy1}, 32'd0);
        check_val("rst_mid_stall", {31'd0, stall1}, 32'd0);
        rstn = 1'b1;
        step("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised successor to the pipeline forwarding logic of the 5-stage MIPS CPU. It produces the same-cycle EX operand and MEM store-data bypass selects, and adds load-use stall detection. It also tracks a multi-cycle multiply/divide unit (MDU) with a countdown scoreboard and stalls dependent instructions in ID. It keeps a saturating stall-cycle performance counter. It sits beside the hazard/control path and drives the PC/IF-ID freeze and the ID/EX bubble.

## Interface
Parameters:
- REG_AW, 5: register address width.
- MDU_LAT, 4: EX cycles an MDU op occupies (legal range 1..15).
- LINK_EXCL, 1: when 1, register 31 (jal link) is never forwarded.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt.
- id_mdu_op  in  1  ID instruction is an MDU op.
- idex_rs, idex_rt, idex_rd  in  REG_AW  ID/EX source and destination registers.
- idex_regwrite, idex_memread, idex_mdu_start  in  1  ID/EX control bits.
- exmem_rd, exmem_rt  in  REG_AW  EX/MEM destination register and store-data source register.
- exmem_regwrite, exmem_memwrite  in  1  EX/MEM control bits.
- memwb_rd  in  REG_AW  MEM/WB destination register.
- memwb_regwrite  in  1  MEM/WB control bit.
- perf_clr  in  1  synchronous clear of stall_cnt.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_c  out  1  MEM store data taken from MEM/WB result.
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
- mdu_busy  out  1  MDU scoreboard counter nonzero.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- A register is valid for forwarding when it is nonzero and, if LINK_EXCL=1, not equal to 31.
- fwd_a:
  - 10 if exmem_regwrite and exmem_rd is valid and exmem_rd==idex_rs.
  - else 01 if memwb_regwrite and memwb_rd is valid and memwb_rd==idex_rs.
  - else 00.
  - EX/MEM always wins over MEM/WB.
- fwd_b: same rule as fwd_a, using idex_rt.
- fwd_c = exmem_memwrite and memwb_regwrite and memwb_rd is valid and memwb_rd==exmem_rt.
- Load-use hazard (load_use): idex_memread and idex_regwrite and idex_rd nonzero and ((id_uses_rs and id_rs==idex_rd) or (id_uses_rt and id_rt==idex_rd)). Register 0 never causes a stall. LINK_EXCL does not suppress load_use.
- MDU scoreboard: state is a 4-bit counter mdu_cnt and a REG_AW register mdu_rd.
  - On an edge with idex_mdu_start=1: mdu_cnt <= MDU_LAT and mdu_rd <= idex_rd.
  - Else, if mdu_cnt != 0: mdu_cnt decrements by 1.
  - mdu_busy = (mdu_cnt != 0).
  - The MDU destination is pending when mdu_busy or idex_mdu_start. The pending register is idex_rd while idex_mdu_start=1, otherwise mdu_rd.
  - mdu_hz = pending and ((id_uses_rs and id_rs==pending register, nonzero) or (id_uses_rt and id_rt==pending register, nonzero) or id_mdu_op).
- stall = load_use or mdu_hz.
- stall_cnt each edge:
  - perf_clr=1: load 0. perf_clr has priority over increment.
  - else stall=1 and stall_cnt not all-ones: +1.
  - else hold. stall_cnt saturates at 2^CNT_W-1 and does not wrap.
- While rstn=0: all outputs are 0, including the combinational fwd_a, fwd_b, fwd_c and stall; mdu_cnt=0, mdu_rd=0, stall_cnt=0.

## Timing
- fwd_a, fwd_b, fwd_c and stall are combinational from the inputs in the same cycle, with zero latency.
- The MDU counter loads on the edge that ends the idex_mdu_start cycle. mdu_busy is 1 for exactly MDU_LAT cycles after that edge.
- With MDU_LAT=1, a dependent ID instruction stalls in the idex_mdu_start cycle and one cycle after it.
- If a new idex_mdu_start coincides with mdu_cnt != 0, the counter reloads and mdu_rd is overwritten. The pipeline prevents this case via id_mdu_op stalling.
- A load-use stall lasts exactly one cycle, because the pipeline bubbles ID/EX and idex_memread drops.
- Reset deasserting mid-MDU operation is not possible; assertion clears the scoreboard immediately and asynchronously.

## Test plan
- EX/MEM versus MEM/WB priority: idex_rs=8, exmem_rd=8, memwb_rd=8, both regwrite=1 -> fwd_a=10. Then drop exmem_regwrite -> fwd_a=01. Then set idex_rs=0 -> fwd_a=00.
- Link exclusion: with LINK_EXCL=1, exmem_rd=31 matching idex_rt -> fwd_b=00. Rebuild with LINK_EXCL=0 -> fwd_b=10.
- Store forward: exmem_memwrite=1, exmem_rt=9, memwb_rd=9, memwb_regwrite=1 -> fwd_c=1. Set memwb_rd=0 -> fwd_c=0.
- Load-use: idex_memread=1, idex_rd=5, id_rt=5, id_uses_rt=1 -> stall=1 for one cycle and stall_cnt +1. With id_uses_rt=0 -> stall=0.
- MDU with MDU_LAT=4: idex_mdu_start for one cycle with idex_rd=12, and ID holds a reader of r12 throughout -> stall=1 for 5 consecutive cycles, mdu_busy=1 for 4 cycles, stall_cnt=5.
- Counter and reset: force stall_cnt to saturation with CNT_W=4 -> holds at 15. perf_clr together with stall -> 0 next edge. Pulse rstn low mid-MDU -> mdu_busy=0 and stall=0 immediately.
